// File: rtl/pipe_hazard_ctl_if.sv
// Bundle between the hazard/pipeline-control unit and the rest of the core.
//
// Handshake: dmem_req is the MEM stage's request and dmem_ready the memory's
// completion strobe. A data-memory access finishes on the rising edge where
// dmem_req && dmem_ready. While dmem_req && !dmem_ready, the access is
// outstanding and the whole pipeline holds. dmem_ready is ignored when
// dmem_req is low.
//
// Signals:
//   ID decode     : id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
//                   id_regwrite, id_memread, id_wrreg
//   branch stage  : br_taken
//   MEM stage     : dmem_req, dmem_ready
//   controls out  : pc_we, ifid_we, ifid_flush, idex_bubble, exmem_bubble,
//                   pipe_freeze, fwd_a, fwd_b
//   counters out  : stall_cnt, flush_cnt, freeze_cnt
//   debug out     : sb_dbg = {ex, mem, wb} scoreboard entries, each
//                   {valid, regwrite, memread, wrreg}
interface pipe_hazard_ctl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_regwrite;
  logic             id_memread;
  logic [REG_W-1:0] id_wrreg;
  logic             br_taken;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             pipe_freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;
  logic [3*(REG_W+3)-1:0] sb_dbg;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_regwrite,
           id_memread, id_wrreg, br_taken, dmem_req, dmem_ready,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_bubble, pipe_freeze,
           fwd_a, fwd_b, stall_cnt, flush_cnt, freeze_cnt, sb_dbg
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_regwrite,
           id_memread, id_wrreg, br_taken, dmem_req, dmem_ready,
    output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_bubble, pipe_freeze,
           fwd_a, fwd_b, stall_cnt, flush_cnt, freeze_cnt, sb_dbg
  );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Hazard detection and pipeline control for the five-stage MIPS core.
// Tracks in-flight register writers in EX/MEM/WB with a small scoreboard and
// drives PC/IF-ID enables, flush/bubble controls, registered EX forwarding
// selects, a whole-pipe freeze during data-memory waits, and saturating
// performance counters.
//
// Parameters:
//   REG_W        register index width
//   BRANCH_STAGE 3 = branches resolve in EX, 4 = in MEM (only legal values)
//   FWD_EN       1 = forward from MEM/WB, 0 = stall until writer leaves MEM
//   CNT_W        performance counter width
//
// Ports:
//   clk   rising-edge clock
//   reset synchronous, active-high
//   hz    pipe_hazard_ctl_if.slave (ID decode, branch, MEM inputs; controls,
//         forwarding selects, counters, scoreboard debug outputs)
module pipe_hazard_ctl #(
  parameter int REG_W        = 5,
  parameter int BRANCH_STAGE = 4,
  parameter int FWD_EN       = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctl_if.slave hz
);

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] wrreg;
  } entry_t;

  // Priority-resolved control mode for the current cycle.
  typedef enum logic [2:0] {
    M_RESET, M_FREEZE, M_FLUSH, M_STALL, M_ADVANCE
  } mode_e;

  localparam entry_t ENTRY_NONE = '0;
  localparam logic   BR_IN_MEM  = (BRANCH_STAGE == 4);
  localparam logic   FWD_ON     = (FWD_EN != 0);

  entry_t ex_q, mem_q, wb_q, id_entry;
  logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  logic ex_w, mem_w;
  logic rs_used, rt_used;
  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic raw_stall;
  mode_e mode;

  // Register 0 is hard-wired, so a write to it is never a real producer.
  function automatic logic is_writer(entry_t e);
    return e.valid && e.regwrite && (e.wrreg != '0);
  endfunction

  assign id_entry = {hz.id_valid, hz.id_regwrite, hz.id_memread, hz.id_wrreg};

  // The wb entry never enters these comparisons: the register file is
  // write-first, so a WB producer is already visible to the ID read.
  always_comb begin
    ex_w    = is_writer(ex_q);
    mem_w   = is_writer(mem_q);
    rs_used = hz.id_valid & hz.id_uses_rs;
    rt_used = hz.id_valid & hz.id_uses_rt;
    ex_rs   = ex_w  & (ex_q.wrreg  == hz.id_rs);
    ex_rt   = ex_w  & (ex_q.wrreg  == hz.id_rt);
    mem_rs  = mem_w & (mem_q.wrreg == hz.id_rs);
    mem_rt  = mem_w & (mem_q.wrreg == hz.id_rt);

    if (FWD_ON) begin
      // Only a load in EX cannot be forwarded in time.
      raw_stall = ex_q.memread & ((rs_used & ex_rs) | (rt_used & ex_rt));
    end else begin
      raw_stall = (rs_used & (ex_rs | mem_rs)) | (rt_used & (ex_rt | mem_rt));
    end

    // EX producer is younger than MEM producer, so it wins.
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (FWD_ON) begin
      if (ex_rs)       fwd_a_d = 2'b01;
      else if (mem_rs) fwd_a_d = 2'b10;
      if (ex_rt)       fwd_b_d = 2'b01;
      else if (mem_rt) fwd_b_d = 2'b10;
    end
  end

  always_comb begin
    if (reset)                              mode = M_RESET;
    else if (hz.dmem_req && !hz.dmem_ready) mode = M_FREEZE;
    else if (hz.br_taken)                   mode = M_FLUSH;
    else if (raw_stall)                     mode = M_STALL;
    else                                    mode = M_ADVANCE;
  end

  always_comb begin
    hz.pc_we        = 1'b1;
    hz.ifid_we      = 1'b1;
    hz.ifid_flush   = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.exmem_bubble = 1'b0;
    hz.pipe_freeze  = 1'b0;
    case (mode)
      M_RESET: begin
        hz.pc_we        = 1'b0;
        hz.ifid_we      = 1'b0;
        hz.ifid_flush   = 1'b1;
        hz.idex_bubble  = 1'b1;
        hz.exmem_bubble = 1'b1;
      end
      M_FREEZE: begin
        hz.pc_we       = 1'b0;
        hz.ifid_we     = 1'b0;
        hz.pipe_freeze = 1'b1;
      end
      M_FLUSH: begin
        // IF/ID stays enabled so it captures the flush bubble.
        hz.ifid_flush   = 1'b1;
        hz.idex_bubble  = 1'b1;
        hz.exmem_bubble = BR_IN_MEM;
      end
      M_STALL: begin
        hz.pc_we       = 1'b0;
        hz.ifid_we     = 1'b0;
        hz.idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= ENTRY_NONE;
      mem_q        <= ENTRY_NONE;
      wb_q         <= ENTRY_NONE;
      fwd_a_q      <= 2'b00;
      fwd_b_q      <= 2'b00;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      case (mode)
        M_FREEZE: begin
          if (freeze_cnt_q != '1) freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
        end
        M_FLUSH: begin
          // With MEM resolution the EX occupant is also on the wrong path.
          ex_q    <= ENTRY_NONE;
          mem_q   <= BR_IN_MEM ? ENTRY_NONE : ex_q;
          wb_q    <= mem_q;
          fwd_a_q <= 2'b00;
          fwd_b_q <= 2'b00;
          if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
        M_STALL: begin
          ex_q    <= ENTRY_NONE;
          mem_q   <= ex_q;
          wb_q    <= mem_q;
          fwd_a_q <= 2'b00;
          fwd_b_q <= 2'b00;
          if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
        default: begin
          ex_q    <= id_entry;
          mem_q   <= ex_q;
          wb_q    <= mem_q;
          fwd_a_q <= fwd_a_d;
          fwd_b_q <= fwd_b_d;
        end
      endcase
    end
  end

  assign hz.fwd_a      = fwd_a_q;
  assign hz.fwd_b      = fwd_b_q;
  assign hz.stall_cnt  = stall_cnt_q;
  assign hz.flush_cnt  = flush_cnt_q;
  assign hz.freeze_cnt = freeze_cnt_q;
  assign hz.sb_dbg     = {ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl. Four instances share one stimulus stream:
//   0: defaults (BRANCH_STAGE=4, FWD_EN=1, CNT_W=32)
//   1: BRANCH_STAGE=3
//   2: FWD_EN=0
//   3: CNT_W=4
// Observed control vector: {pc_we, ifid_we, ifid_flush, idex_bubble,
// exmem_bubble, pipe_freeze, fwd_a, fwd_b}.
module tb_pipe_hazard_ctl;

  localparam logic [5:0] C_NORM  = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_FL4   = 6'b111110;
  localparam logic [5:0] C_FL3   = 6'b111100;
  localparam logic [5:0] C_FRZ   = 6'b000001;
  localparam logic [5:0] C_RST   = 6'b001110;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       mr;
    logic [4:0] wr;
    logic       br;
    logic       dreq;
    logic       drdy;
  } stim_t;

  logic clk, rst;
  logic id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic [4:0] id_rs, id_rt, id_wrreg;
  logic br_taken, dmem_req, dmem_ready;

  logic [9:0]  obs_v [4];
  logic [31:0] st_c  [4];
  logic [31:0] fl_c  [4];
  logic [31:0] fz_c  [4];
  logic [23:0] sb_v  [4];

  logic [9:0] exp_q[$];
  int checks;
  int failures;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CW = (g == 3) ? 4 : 32;
    pipe_hazard_ctl_if #(.REG_W(5), .CNT_W(CW)) bus ();
    assign bus.id_valid    = id_valid;
    assign bus.id_rs       = id_rs;
    assign bus.id_rt       = id_rt;
    assign bus.id_uses_rs  = id_uses_rs;
    assign bus.id_uses_rt  = id_uses_rt;
    assign bus.id_regwrite = id_regwrite;
    assign bus.id_memread  = id_memread;
    assign bus.id_wrreg    = id_wrreg;
    assign bus.br_taken    = br_taken;
    assign bus.dmem_req    = dmem_req;
    assign bus.dmem_ready  = dmem_ready;
    pipe_hazard_ctl #(
      .REG_W(5),
      .BRANCH_STAGE((g == 1) ? 3 : 4),
      .FWD_EN((g == 2) ? 0 : 1),
      .CNT_W(CW)
    ) u_dut (
      .clk(clk),
      .reset(rst),
      .hz(bus)
    );
    assign obs_v[g] = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble,
                       bus.exmem_bubble, bus.pipe_freeze, bus.fwd_a, bus.fwd_b};
    assign st_c[g] = 32'(bus.stall_cnt);
    assign fl_c[g] = 32'(bus.flush_cnt);
    assign fz_c[g] = 32'(bus.freeze_cnt);
    assign sb_v[g] = bus.sb_dbg;
  end

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at 200000, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic stim_t ins(logic v, logic [4:0] rs, logic [4:0] rt,
                                logic urs, logic urt, logic rw, logic mr,
                                logic [4:0] wr);
    stim_t s;
    s = '{v: v, rs: rs, rt: rt, urs: urs, urt: urt, rw: rw, mr: mr, wr: wr,
          br: 1'b0, dreq: 1'b0, drdy: 1'b1};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_valid    = s.v;
    id_rs       = s.rs;
    id_rt       = s.rt;
    id_uses_rs  = s.urs;
    id_uses_rt  = s.urt;
    id_regwrite = s.rw;
    id_memread  = s.mr;
    id_wrreg    = s.wr;
    br_taken    = s.br;
    dmem_req    = s.dreq;
    dmem_ready  = s.drdy;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    rst = 1'b1;
    apply(ins(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [9:0] got, want;
    rst = 1'b1;
    apply(ins(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k += 3) begin
      exp_q.push_back({C_RST, 2'b00, 2'b00});
      @(negedge clk);
      got = obs_v[k]; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL reset_ctl inst %0d: got %b want %b", k, got, want);
      end
      checks++;
      if ({st_c[k], fl_c[k], fz_c[k]} !== 96'd0) begin
        failures++; $display("FAIL reset_cnt inst %0d: got %0d/%0d/%0d want 0/0/0", k, st_c[k], fl_c[k], fz_c[k]);
      end
      checks++;
      if ({sb_v[k][23], sb_v[k][15], sb_v[k][7]} !== 3'b000) begin
        failures++; $display("FAIL reset_sb inst %0d: got %b want 000", k, {sb_v[k][23], sb_v[k][15], sb_v[k][7]});
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back({C_NORM, 2'b00, 2'b00});
    @(negedge clk);
    got = obs_v[0]; want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL reset_release: got %b want %b", got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    stim_t s [4];
    logic [9:0] e [4];
    logic [9:0] got, want;
    do_reset();
    s[0] = ins(1, 1, 0, 1, 0, 1, 1, 2);  e[0] = {C_NORM,  2'b00, 2'b00}; // lw $2
    s[1] = ins(1, 2, 4, 1, 1, 1, 0, 3);  e[1] = {C_STALL, 2'b00, 2'b00}; // add $3,$2,$4
    s[2] = s[1];                         e[2] = {C_NORM,  2'b00, 2'b00};
    s[3] = ins(0, 0, 0, 0, 0, 0, 0, 0);  e[3] = {C_NORM,  2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got = obs_v[0]; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL load_use step %0d: got %b want %b", i, got, want);
      end
      if (i == 2) begin
        checks++;
        if ({sb_v[0][23], sb_v[0][15], sb_v[0][7]} !== 3'b010) begin
          failures++; $display("FAIL load_use_sb: got %b want 010", {sb_v[0][23], sb_v[0][15], sb_v[0][7]});
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (st_c[0] !== 32'd1) begin
      failures++; $display("FAIL load_use_stall_cnt: got %0d want 1", st_c[0]);
    end
  endtask

  task automatic test_alu_forward();
    stim_t s [6];
    logic [9:0] e [6];
    logic [9:0] got, want;
    do_reset();
    s[0] = ins(1, 1, 1, 1, 1, 1, 0, 5);  e[0] = {C_NORM, 2'b00, 2'b00}; // add $5
    s[1] = ins(1, 1, 5, 1, 1, 1, 0, 6);  e[1] = {C_NORM, 2'b00, 2'b00}; // reads $5 as rt
    s[2] = ins(1, 5, 2, 1, 1, 1, 0, 5);  e[2] = {C_NORM, 2'b00, 2'b01}; // two later, reads rs
    s[3] = ins(1, 1, 1, 1, 1, 1, 0, 5);  e[3] = {C_NORM, 2'b10, 2'b00}; // another $5 writer
    s[4] = ins(1, 5, 0, 1, 1, 1, 0, 7);  e[4] = {C_NORM, 2'b00, 2'b00}; // ex and mem both $5
    s[5] = ins(0, 0, 0, 0, 0, 0, 0, 0);  e[5] = {C_NORM, 2'b01, 2'b00};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got = obs_v[0]; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL alu_fwd step %0d: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    stim_t s [4];
    logic [9:0] e0 [4];
    logic [9:0] e1 [4];
    logic [9:0] got, want;
    do_reset();
    s[0] = ins(1, 1, 1, 1, 1, 1, 1, 7);  // lw $7, younger than the branch
    s[1] = ins(1, 7, 3, 1, 1, 1, 0, 9);  // reader of $7, coincident with branch
    s[1].br = 1'b1;
    s[2] = ins(1, 7, 3, 1, 1, 1, 0, 9);
    s[3] = ins(0, 0, 0, 0, 0, 0, 0, 0);
    e0 = '{{C_NORM, 4'b0000}, {C_FL4, 4'b0000}, {C_NORM, 4'b0000}, {C_NORM, 4'b0000}};
    e1 = '{{C_NORM, 4'b0000}, {C_FL3, 4'b0000}, {C_NORM, 4'b0000}, {C_NORM, 4'b1000}};
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      exp_q.push_back(e0[i]);
      exp_q.push_back(e1[i]);
      @(negedge clk);
      got = obs_v[0]; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL branch_stage4 step %0d: got %b want %b", i, got, want);
      end
      got = obs_v[1]; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL branch_stage3 step %0d: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (fl_c[k] !== 32'd1 || st_c[k] !== 32'd0) begin
        failures++; $display("FAIL branch_cnt inst %0d: got flush %0d stall %0d want flush 1 stall 0", k, fl_c[k], st_c[k]);
      end
    end
  endtask

  task automatic test_freeze();
    stim_t s [7];
    logic [9:0] e [7];
    logic [9:0] got, want;
    do_reset();
    s[0] = ins(1, 1, 1, 1, 1, 1, 0, 7);  e[0] = {C_NORM, 4'b0000};
    s[1] = ins(1, 7, 1, 1, 1, 1, 0, 9);  e[1] = {C_NORM, 4'b0000};
    for (int i = 2; i < 5; i++) begin
      s[i] = ins(1, 9, 7, 1, 1, 1, 0, 10);
      s[i].br = 1'b1; s[i].dreq = 1'b1; s[i].drdy = 1'b0;
      e[i] = {C_FRZ, 4'b0100};
    end
    s[5] = ins(1, 9, 7, 1, 1, 1, 0, 10);
    s[5].br = 1'b1; s[5].dreq = 1'b1;   e[5] = {C_FL4, 4'b0100};
    s[6] = ins(0, 0, 0, 0, 0, 0, 0, 0);  e[6] = {C_NORM, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got = obs_v[0]; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL freeze step %0d: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (fz_c[0] !== 32'd3 || fl_c[0] !== 32'd1) begin
      failures++; $display("FAIL freeze_cnt: got freeze %0d flush %0d want freeze 3 flush 1", fz_c[0], fl_c[0]);
    end
  endtask

  task automatic test_fwd_off();
    stim_t s [7];
    logic [9:0] e [7];
    logic [9:0] got, want;
    do_reset();
    s[0] = ins(1, 1, 1, 1, 1, 1, 0, 5);  e[0] = {C_NORM,  4'b0000}; // add $5
    s[1] = ins(1, 5, 2, 1, 1, 1, 0, 6);  e[1] = {C_STALL, 4'b0000};
    s[2] = s[1];                         e[2] = {C_STALL, 4'b0000};
    s[3] = s[1];                         e[3] = {C_NORM,  4'b0000};
    s[4] = ins(1, 1, 1, 1, 1, 1, 0, 0);  e[4] = {C_NORM,  4'b0000}; // writes $0
    s[5] = ins(1, 0, 0, 1, 1, 1, 0, 8);  e[5] = {C_NORM,  4'b0000}; // reads $0
    s[6] = ins(0, 0, 0, 0, 0, 0, 0, 0);  e[6] = {C_NORM,  4'b0000};
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got = obs_v[2]; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL fwd_off step %0d: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (st_c[2] !== 32'd2) begin
      failures++; $display("FAIL fwd_off_stall_cnt: got %0d want 2", st_c[2]);
    end
  endtask

  task automatic test_saturate_and_reset();
    logic [9:0] got, want;
    logic [4:0] r, r_prev;
    logic [31:0] want_cnt;
    stim_t s;
    do_reset();
    r_prev = 5'd0;
    for (int i = 0; i < 20; i++) begin
      r = 5'($urandom_range(1, 31));
      s = ins(1, r, 0, 1, 0, 1, 1, r);   // lw $r, 0($r): self load-use
      apply(s);
      exp_q.push_back({C_NORM, 4'b0000});
      @(negedge clk);
      got = obs_v[3]; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL sat_adv iter %0d: got %b want %b", i, got, want);
      end
      want_cnt = (i > 15) ? 32'd15 : 32'(i);
      checks++;
      if (st_c[3] !== want_cnt) begin
        failures++; $display("FAIL sat_cnt iter %0d: got %0d want %0d", i, st_c[3], want_cnt);
      end
      @(posedge clk);
      #1;
      exp_q.push_back({C_STALL, ((i > 0) && (r == r_prev)) ? 2'b10 : 2'b00, 2'b00});
      @(negedge clk);
      got = obs_v[3]; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++; $display("FAIL sat_stall iter %0d: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
      r_prev = r;
    end
    checks++;
    if (st_c[3] !== 32'd15) begin
      failures++; $display("FAIL sat_final: got %0d want 15", st_c[3]);
    end

    // Set up a load-use stall, then reset during it with memory also waiting.
    s = ins(1, 3, 0, 1, 0, 1, 1, 3);
    apply(s);
    @(posedge clk);
    #1;
    s.dreq = 1'b1; s.drdy = 1'b0;
    apply(s);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_v[3][9:4] !== C_RST) begin
      failures++; $display("FAIL reset_mid_stall_ctl: got %b want %b", obs_v[3][9:4], C_RST);
    end
    @(posedge clk);
    #1;
    exp_q.push_back({C_RST, 4'b0000});
    @(negedge clk);
    got = obs_v[3]; want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL reset_mid_fwd: got %b want %b", got, want);
    end
    checks++;
    if ({st_c[3], fl_c[3], fz_c[3]} !== 96'd0) begin
      failures++; $display("FAIL reset_mid_cnt: got %0d/%0d/%0d want 0/0/0", st_c[3], fl_c[3], fz_c[3]);
    end
    checks++;
    if ({sb_v[3][23], sb_v[3][15], sb_v[3][7]} !== 3'b000) begin
      failures++; $display("FAIL reset_mid_sb: got %b want 000", {sb_v[3][23], sb_v[3][15], sb_v[3][7]});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    s.dreq = 1'b0; s.drdy = 1'b1;
    apply(s);
    exp_q.push_back({C_NORM, 4'b0000});
    @(negedge clk);
    got = obs_v[3]; want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++; $display("FAIL reset_no_residual: got %b want %b", got, want);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    apply(ins(0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_load_use();
    test_alu_forward();
    test_branch();
    test_freeze();
    test_fwd_off();
    test_saturate_and_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
Parametrised hazard and pipeline-control unit for the five-stage MIPS core. It tracks in-flight register writers in EX/MEM/WB with an internal scoreboard and produces:
- PC and IF/ID write enables.
- Flush and bubble controls for branches and load-use stalls.
- Registered forwarding selects for the EX-stage ALU operands.
- Whole-pipeline freeze while data memory is not ready.
It also keeps saturating performance counters. It sits beside the stage modules in the CPU top and is driven from ID decode, the branch-resolving stage and the MEM stage.

Parameters:
REG_W, 5, register-index width.
BRANCH_STAGE, 4, stage resolving branches: 3 (EX) or 4 (MEM); any other value is illegal.
FWD_EN, 1, 1 = forward from MEM/WB; 0 = stall until the writer leaves MEM.
CNT_W, 32, performance-counter width.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
id_valid  in  1  ID holds a real instruction.
id_rs  in  REG_W  ID source register rs.
id_rt  in  REG_W  ID source register rt.
id_uses_rs  in  1  ID instruction reads rs.
id_uses_rt  in  1  ID instruction reads rt.
id_regwrite  in  1  ID instruction writes a register.
id_memread  in  1  ID instruction is a load.
id_wrreg  in  REG_W  ID destination register (after regdst mux).
br_taken  in  1  taken branch in stage BRANCH_STAGE.
dmem_req  in  1  MEM stage accessing data memory.
dmem_ready  in  1  data memory completes this cycle.
pc_we  out  1  PC may update.
ifid_we  out  1  IF/ID register may load.
ifid_flush  out  1  IF/ID loads a bubble.
idex_bubble  out  1  ID/EX loads a bubble.
exmem_bubble  out  1  EX/MEM loads a bubble (BRANCH_STAGE=4 only).
pipe_freeze  out  1  all pipeline registers hold.
fwd_a  out  2  EX operand A source: 00 regfile, 01 MEM result, 10 WB data.
fwd_b  out  2  EX operand B source, same encoding.
stall_cnt  out  CNT_W  load-use/RAW stall cycles.
flush_cnt  out  CNT_W  branch-flush events.
freeze_cnt  out  CNT_W  memory-freeze cycles.

Behaviour:
- Scoreboard: three entries ex, mem, wb, each {valid, regwrite, memread, wrreg}. An entry is a writer only if valid & regwrite & wrreg != 0. Register 0 never causes a hazard or a forward.
- The register file is write-first, so a wb-entry match is never a hazard and is never forwarded.
- Priority, highest first: reset > freeze > branch flush > stall > normal advance.
- Reset (sync):
  - All entries invalid; fwd_a/fwd_b = 00; all counters = 0.
  - While reset is high: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, exmem_bubble=1, pipe_freeze=0.
- Freeze: when dmem_req & !dmem_ready:
  - pipe_freeze=1, pc_we=0, ifid_we=0, all bubbles/flush 0.
  - Scoreboard and fwd registers hold; freeze_cnt increments.
  - br_taken is ignored while frozen. The branch stage holds it, so it acts on the first unfrozen cycle.
- Branch flush (br_taken, not frozen):
  - pc_we=1, ifid_flush=1, idex_bubble=1; exmem_bubble = 1 if BRANCH_STAGE=4, else 0.
  - Next state, BRANCH_STAGE=4: ex<=invalid, mem<=invalid, wb<=mem.
  - Next state, BRANCH_STAGE=3: ex<=invalid, mem<=ex, wb<=mem.
  - flush_cnt increments once. A coincident stall is discarded.
- Hazard detection (combinational, in ID): a source is "used" if id_valid and its uses_ flag is set.
  - FWD_EN=1: stall iff ex is a writer with memread=1 and ex.wrreg equals a used source (load-use).
  - FWD_EN=0: stall iff ex or mem is a writer matching a used source.
- Stall (not frozen, no flush): pc_we=0, ifid_we=0, idex_bubble=1. Next state: ex<=invalid, mem<=ex, wb<=mem. stall_cnt increments.
- Normal advance: pc_we=1, ifid_we=1, bubbles/flush 0. Next state: ex<={id_valid, id_regwrite, id_memread, id_wrreg}, mem<=ex, wb<=mem.
- Forwarding selects (registered; valid while the instruction is in EX):
  - Updated on normal advance only. Reset to 00 on stall, flush or bubble; held on freeze.
  - fwd_a = 01 if the current ex entry is a writer matching id_rs; else 10 if the current mem entry matches; else 00. ex takes precedence over mem.
  - fwd_b is the same using id_rt.
  - FWD_EN=0 forces 00.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-freeze clears everything the next edge; no residual stall.

Test Plan:
- Load-use: lw $2 in EX; ID add $3,$2,$4 -> one cycle with pc_we=0, idex_bubble=1, stall_cnt=1; next cycle advances with fwd_a=10.
- ALU forward: add $5 in EX, ID uses $5 as rt -> no stall; fwd_b=01 the next cycle. An instruction two later -> fwd=10.
- Branch, BRANCH_STAGE=4 and 3: br_taken one cycle -> ifid_flush=1, idex_bubble=1, exmem_bubble=1 (0 for stage 3). flush_cnt=1. A younger writer to $7 is never forwarded.
- Freeze: dmem_req=1, dmem_ready low 3 cycles, br_taken high throughout -> pipe_freeze=1 for 3 cycles, freeze_cnt=3; flush occurs on cycle 4, flush_cnt=1.
- FWD_EN=0: add $5 followed by a reader of $5 -> 2 stall cycles; fwd always 00. A writer to $0 -> 0 stalls.
- CNT_W=4: 20 consecutive load-use stalls -> stall_cnt stays at 15. Reset mid-stall -> all counters 0, fwd 00, ex/mem/wb invalid.
